ram_initiator: RTL and testbench

Load/store initiator that owns the single-port 256x16 data RAM port. It accepts one memory request at a time from the processor datapath over a valid/ready handshake and sequences the RAM's write-enable, address and data lines. It absorbs the RAM's registered read latency and returns read data, or a write acknowledge, as a one-cycle response pulse. It sits between the datapath's load/store stage and the RAM wrapper and is the only driver of the RAM port.

---
 rtl/ram_initiator.sv | 135 +++++++++++++
 tb/tb_ram_initiator.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_initiator.sv
// ram_initiator: single-outstanding load/store sequencer that owns the RAM port.
// Loads wait out the RAM read latency and return data on a one-cycle rsp_valid
// pulse; stores issue a one-cycle ram_we and are acknowledged the same way.
// Define RAM_INITIATOR_BYTE_WRITE_EN to honour req_be. Partial-byte stores then
// become read-modify-write sequences, and be=2'b00 is acknowledged without a
// write. With the macro undefined, every store is a full-word write.
module ram_initiator #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  // Wait counter preload: the wait state spans RD_LAT+1 cycles, ending on the
  // cycle in which ram_dout holds the word for the address driven in cycle N+1.
  localparam logic [1:0] LatCnt = 2'(RD_LAT);

`ifdef RAM_INITIATOR_BYTE_WRITE_EN
  typedef enum logic [2:0] {StIdle, StWr, StRdWait, StRmwWait, StRmwWr} state_e;

  logic [1:0]        be;
  logic [DATA_W-1:0] merged;

  // Keep the enabled store bytes (held in ram_din), fill the rest from the RAM.
  always_comb begin
    merged = ram_dout;
    if (be[1]) merged[15:8] = ram_din[15:8];
    if (be[0]) merged[7:0]  = ram_din[7:0];
  end
`else
  typedef enum logic [1:0] {StIdle, StWr, StRdWait} state_e;

  logic unused_be;
  assign unused_be = ^req_be;
`endif

  state_e     state;
  logic [1:0] cnt;

  assign req_ready = (state == StIdle);
  assign busy      = (state != StIdle);

  // Request sequencing with registered RAM controls and response outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= StIdle;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
`ifdef RAM_INITIATOR_BYTE_WRITE_EN
      be        <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      ram_we    <= 1'b0;
      case (state)
        StIdle: begin
          if (req_valid) begin
            ram_addr <= req_addr;
            ram_din  <= req_wdata;
            if (req_we) begin
`ifdef RAM_INITIATOR_BYTE_WRITE_EN
              be <= req_be;
              if (req_be == 2'b11) begin
                state  <= StWr;
                ram_we <= 1'b1;
              end else if (req_be == 2'b00) begin
                // Acknowledged like a store, but the RAM is left untouched.
                state <= StWr;
              end else begin
                state <= StRmwWait;
                cnt   <= LatCnt;
              end
`else
              state  <= StWr;
              ram_we <= 1'b1;
`endif
            end else begin
              state <= StRdWait;
              cnt   <= LatCnt;
            end
          end
        end
        StWr: begin
          state     <= StIdle;
          rsp_valid <= 1'b1;
        end
        StRdWait: begin
          if (cnt == 2'd0) begin
            rsp_rdata <= ram_dout;
            rsp_valid <= 1'b1;
            state     <= StIdle;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
`ifdef RAM_INITIATOR_BYTE_WRITE_EN
        StRmwWait: begin
          if (cnt == 2'd0) begin
            ram_din <= merged;
            ram_we  <= 1'b1;
            state   <= StRmwWr;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        StRmwWr: begin
          state     <= StIdle;
          rsp_valid <= 1'b1;
        end
`endif
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_initiator.sv
// Scoreboard bench for ram_initiator: the stimulus process predicts each
// response and RAM write from a word-level memory model and queues it; an
// independent negedge monitor checks every rsp_valid / ram_we against the queue.
module tb_ram_initiator;

  localparam int RD_LAT = 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        busy;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;

  ram_initiator #(
    .ADDR_W(8),
    .DATA_W(16),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_be   (req_be),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .busy     (busy),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  function automatic logic [15:0] init_word(input int i);
    if (i == 255) return 16'hA5A5;
    return 16'(i * 291) ^ 16'h5A3C;
  endfunction

  // RAM wrapper model: synchronous write, registered read of RD_LAT cycles.
  logic [15:0] mem [256];
  logic [15:0] pipe [RD_LAT];
  bit          ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      ram_init <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_din;
    end
    pipe[0] <= mem[ram_addr];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_dout = pipe[RD_LAT-1];

  // Reference state and scoreboard queues (cycle k = period ending at edge k).
  typedef struct {int acc; int cyc; logic [15:0] data;} rsp_t;
  typedef struct {int cyc; logic [7:0] addr; logic [15:0] data;} wr_t;
  rsp_t        rsp_q[$];
  wr_t         wr_q[$];
  logic [15:0] ref_mem [256];
  logic [15:0] last_ld = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc + 1);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_ram_we"},    32'(ram_we),    32'd0);
    chk({tag, "_ram_addr"},  32'(ram_addr),  32'd0);
    chk({tag, "_ram_din"},   32'(ram_din),   32'd0);
  endtask

  // Call at a negedge. Waits for req_ready, predicts the outcome, and returns
  // at the negedge of cycle acc+1 with req_valid dropped.
  task automatic issue(input logic we, input logic [7:0] a, input logic [15:0] d,
                       input logic [1:0] be, output int acc);
    int n;
    int guard;
`ifdef RAM_INITIATOR_BYTE_WRITE_EN
    logic [15:0] mask;
    logic [15:0] newv;
`endif
    guard = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    while (!req_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL accept_timeout: req_ready=%0b after %0d cycles, expected 1", req_ready, guard);
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    n = cyc + 1;
    acc = n;
    if (!we) begin
      last_ld = ref_mem[a];
      rsp_q.push_back('{acc: n, cyc: n + 2 + RD_LAT, data: last_ld});
    end else begin
`ifdef RAM_INITIATOR_BYTE_WRITE_EN
      mask = {{8{be[1]}}, {8{be[0]}}};
      newv = (d & mask) | (ref_mem[a] & ~mask);
      if (be == 2'b11) begin
        wr_q.push_back('{cyc: n + 1, addr: a, data: d});
        rsp_q.push_back('{acc: n, cyc: n + 2, data: last_ld});
      end else if (be == 2'b00) begin
        rsp_q.push_back('{acc: n, cyc: n + 2, data: last_ld});
      end else begin
        wr_q.push_back('{cyc: n + 2 + RD_LAT, addr: a, data: newv});
        rsp_q.push_back('{acc: n, cyc: n + 3 + RD_LAT, data: last_ld});
      end
      ref_mem[a] = newv;
`else
      wr_q.push_back('{cyc: n + 1, addr: a, data: d});
      rsp_q.push_back('{acc: n, cyc: n + 2, data: last_ld});
      ref_mem[a] = d;
`endif
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Monitor: checks handshake state every cycle and every DUT output event.
  int   mon_cur;
  logic mon_busy;
  rsp_t mon_rsp;
  wr_t  mon_wr;
  always @(negedge clk) begin
    if (reset_n) begin
      mon_cur  = cyc + 1;
      mon_busy = (rsp_q.size() > 0) && (mon_cur > rsp_q[0].acc) && (mon_cur < rsp_q[0].cyc);
      chk("busy", 32'(busy), 32'(mon_busy));
      chk("req_ready", 32'(req_ready), 32'(!mon_busy));
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_rsp: rsp_valid=1 at cycle %0d, expected 0", mon_cur);
        end else begin
          mon_rsp = rsp_q.pop_front();
          chk("rsp_cycle", 32'(mon_cur), 32'(mon_rsp.cyc));
          chk("rsp_rdata", 32'(rsp_rdata), 32'(mon_rsp.data));
        end
      end else if (rsp_q.size() > 0 && mon_cur >= rsp_q[0].cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_rsp: rsp_valid=0 at cycle %0d, expected 1", mon_cur);
        void'(rsp_q.pop_front());
      end
      if (ram_we) begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_we: ram_we=1 at cycle %0d addr 0x%0h, expected 0",
                   mon_cur, ram_addr);
        end else begin
          mon_wr = wr_q.pop_front();
          chk("we_cycle", 32'(mon_cur), 32'(mon_wr.cyc));
          chk("we_addr", 32'(ram_addr), 32'(mon_wr.addr));
          chk("we_data", 32'(ram_din), 32'(mon_wr.data));
        end
      end else if (wr_q.size() > 0 && mon_cur >= wr_q[0].cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_we: ram_we=0 at cycle %0d, expected 1", mon_cur);
        void'(wr_q.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  int          n1, n2, n3, n4;
  int          guard;
  logic [7:0]  ra;
  logic [15:0] old_word;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;

    // Reset with random inputs toggling.
    repeat (4) begin
      @(negedge clk);
      req_valid = 1'($urandom);
      req_we    = 1'($urandom);
      req_addr  = 8'($urandom);
      req_wdata = 16'($urandom);
      req_be    = 2'($urandom);
      #1 check_reset_vals("in_reset");
    end
    @(negedge clk);
    req_valid = 1'b0;
    #2 reset_n = 1'b1;
    @(negedge clk);
    check_reset_vals("post_release");

    // Store then load at 8'h3C.
    issue(1'b1, 8'h3C, 16'hBEEF, 2'b11, n1);
    issue(1'b0, 8'h3C, 16'h0000, 2'b11, n2);
    chk("st_ld_accept", 32'(n2), 32'(n1 + 2));

    // Back-to-back with req_valid held across requests.
    issue(1'b1, 8'h00, 16'h1111, 2'b11, n1);
    issue(1'b0, 8'h00, 16'h0000, 2'b11, n2);
    issue(1'b0, 8'hFF, 16'h0000, 2'b11, n3);
    issue(1'b1, 8'h01, 16'h2222, 2'b11, n4);
    chk("b2b_accept_after_store", 32'(n2), 32'(n1 + 2));
    chk("b2b_accept_after_load", 32'(n3), 32'(n2 + 2 + RD_LAT));
    chk("b2b_accept_after_load2", 32'(n4), 32'(n3 + 2 + RD_LAT));

`ifdef RAM_INITIATOR_BYTE_WRITE_EN
    // Byte-enable stores: high-byte RMW, empty enable, then read back.
    issue(1'b1, 8'h20, 16'h1234, 2'b11, n1);
    issue(1'b1, 8'h20, 16'hABCD, 2'b10, n2);
    issue(1'b1, 8'h20, 16'h9999, 2'b00, n3);
    issue(1'b0, 8'h20, 16'h0000, 2'b11, n4);
    chk("rmw_accept", 32'(n3), 32'(n2 + 3 + RD_LAT));
    issue(1'b1, 8'h21, 16'h5A5A, 2'b01, n1);
    issue(1'b0, 8'h21, 16'h0000, 2'b11, n2);
`endif

    // Reset during the read wait of a load: no response, clean restart.
    issue(1'b0, 8'h3C, 16'h0000, 2'b11, n1);
    #2 reset_n = 1'b0;
    rsp_q.delete();
    wr_q.delete();
    last_ld = 16'h0000;
    #1 check_reset_vals("abort_load");
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    #1 chk("ready_after_release", 32'(req_ready), 32'd1);
    @(negedge clk);
    issue(1'b0, 8'h3C, 16'h0000, 2'b11, n1);

    // Reset during WR: the write must not reach the RAM.
    old_word = ref_mem[8'h50];
    issue(1'b1, 8'h50, 16'hDEAD, 2'b11, n1);
    #2 reset_n = 1'b0;
    rsp_q.delete();
    wr_q.delete();
    last_ld = 16'h0000;
    ref_mem[8'h50] = old_word;
    #1 check_reset_vals("abort_store");
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    issue(1'b0, 8'h50, 16'h0000, 2'b11, n1);

    // Randomized traffic over a small address window plus both boundaries.
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 9) == 0) ra = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
      else ra = {5'b01000, 3'($urandom_range(0, 7))};
      issue($urandom_range(0, 1) == 1, ra, 16'($urandom), 2'($urandom_range(0, 3)), n1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Drain outstanding expectations.
    guard = 0;
    while ((rsp_q.size() > 0 || wr_q.size() > 0) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_rsp_q", 32'(rsp_q.size()), 32'd0);
    chk("drain_wr_q", 32'(wr_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
